fwrisc_bus_arb: RTL

Parametrised N-master round-robin arbiter that merges several fwrisc-style valid/ready memory ports onto one memory-side port. Masters can be the instruction and data ports of one core, or the ports of several cores in a cluster. The block sits between the cores' `iaddr`/`ivalid`/`iready` and `daddr`/`dvalid`/`dready` buses and a single memory or interconnect target. It holds a grant for the full duration of each transaction and can optionally abort stalled transactions.

---
 rtl/fwrisc_bus_arb_pkg.sv | 20 ++
 rtl/fwrisc_rr_pick.sv | 35 +++
 rtl/fwrisc_bus_arb.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fwrisc_bus_arb_pkg.sv
// Shared types and helpers for the fwrisc bus arbiter family.
package fwrisc_bus_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_DEFAULT_TIMEOUT = 255;
    localparam int ARB_TO_CNT_WIDTH    = 16;

    // Index width for n ports; never below 1 so a 1-bit index still exists.
    function automatic int arb_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fwrisc_rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr, else lowest overall.
module fwrisc_rr_pick
    import fwrisc_bus_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = arb_clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [N-1:0]     upper;
    logic [IDX_W-1:0] upper_idx;
    logic [IDX_W-1:0] low_idx;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        upper     = '0;
        upper_idx = '0;
        low_idx   = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = req[i] && (i >= int'(ptr));
        end
        // Descending scan: the last hit written is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (upper[i]) upper_idx = IDX_W'(i);
            if (req[i])   low_idx   = IDX_W'(i);
        end
        gnt_idx = (|upper) ? upper_idx : low_idx;
        gnt     = (|req) ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/fwrisc_bus_arb.sv
// N-master round-robin arbiter for fwrisc valid/ready ports, grant held per transaction.
// Optional stall abort is built when FWRISC_BUS_ARB_TIMEOUT_EN is defined.
module fwrisc_bus_arb
    import fwrisc_bus_arb_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = ARB_DEFAULT_TIMEOUT
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [N_MASTERS-1:0]                m_valid,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]     m_addr,
    input  logic [N_MASTERS-1:0]                m_write,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]     m_wdata,
    input  logic [N_MASTERS*(DATA_WIDTH/8)-1:0] m_wstb,
    output logic [N_MASTERS-1:0]                m_ready,
    output logic [DATA_WIDTH-1:0]               m_rdata,
    output logic [N_MASTERS-1:0]                m_err,
    output logic                                s_valid,
    output logic [ADDR_WIDTH-1:0]               s_addr,
    output logic                                s_write,
    output logic [DATA_WIDTH-1:0]               s_wdata,
    output logic [(DATA_WIDTH/8)-1:0]           s_wstb,
    input  logic [DATA_WIDTH-1:0]               s_rdata,
    input  logic                                s_ready,
    output logic [arb_clog2(N_MASTERS)-1:0]     grant_id
);

    localparam int IDX_W = arb_clog2(N_MASTERS);
    localparam int STB_W = DATA_WIDTH / 8;

    if (N_MASTERS < 2 || N_MASTERS > 8 || (DATA_WIDTH % 8) != 0 ||
        TIMEOUT < 1 || TIMEOUT >= (1 << ARB_TO_CNT_WIDTH)) begin : g_bad_cfg
        $error("fwrisc_bus_arb: unsupported parameter combination");
    end

    arb_state_t           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     next_ptr;
    logic [N_MASTERS-1:0] grant_oh;
    logic [N_MASTERS-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 complete;
    logic                 abort;
    logic                 finish;

    fwrisc_rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (m_valid),
        .ptr     (rr_ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

`ifdef FWRISC_BUS_ARB_TIMEOUT_EN
    logic [ARB_TO_CNT_WIDTH-1:0] to_cnt;
    assign abort = (state == ARB_BUSY) && !s_ready &&
                   (to_cnt == ARB_TO_CNT_WIDTH'(TIMEOUT));
`else
    assign abort = 1'b0;
`endif

    assign complete = (state == ARB_BUSY) && s_ready;
    assign finish   = complete || abort;
    assign next_ptr = (grant_id == IDX_W'(N_MASTERS - 1)) ? '0 : grant_id + 1'b1;

    // Request fields follow grant_id in every state; only s_valid qualifies them.
    assign s_addr  = m_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_write = m_write[grant_id];
    assign s_wdata = m_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign s_wstb  = m_wstb[grant_id*STB_W +: STB_W];

    // Zero-cycle return path: completion is visible in the same cycle as s_ready.
    assign m_ready = finish ? grant_oh : '0;
    assign m_err   = abort  ? grant_oh : '0;
    assign m_rdata = abort  ? '0 : s_rdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            grant_oh <= N_MASTERS'(1);
            s_valid  <= 1'b0;
`ifdef FWRISC_BUS_ARB_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|m_valid) begin
                        grant_id <= pick_idx;
                        grant_oh <= pick_gnt;
                        s_valid  <= 1'b1;
                        state    <= ARB_BUSY;
`ifdef FWRISC_BUS_ARB_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                ARB_BUSY: begin
                    if (finish) begin
                        s_valid <= 1'b0;
                        rr_ptr  <= next_ptr;
                        state   <= ARB_IDLE;
                    end
`ifdef FWRISC_BUS_ARB_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
